posit_stream_checker: RTL

- Synthesizable, parametrised checker for posit arithmetic pipelines (posit_adder_8 and wider successors).
- Aligns a stream of golden results with a DUT output stream whose latency is fixed and compile-time known, and computes the absolute difference of the posit codes.
- Accumulates vector, error and protocol-fault counters and the maximum difference seen.
- Sits beside the DUT in benches and on-chip self-test, and replaces per-bench $fwrite comparison.

---
 rtl/posit_chk_pkg.sv | 22 ++
 rtl/posit_chk_delay.sv | 34 +++
 rtl/posit_stream_checker.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/posit_chk_pkg.sv
// Shared state encoding and arithmetic helpers for the posit stream checker.
package posit_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } chk_state_e;

    // Callers zero-extend N-bit posit codes to 64 bits and truncate the result back.
    function automatic logic [63:0] abs_diff(input logic [63:0] a, input logic [63:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    function automatic logic [63:0] sat_inc(input logic [63:0] v, input int unsigned w);
        logic [63:0] max_v;
        max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
        return (v >= max_v) ? v : (v + 64'd1);
    endfunction

endpackage

// File: rtl/posit_chk_delay.sv
// Fixed-depth shift register of {valid, data}; reused for any DUT latency.
module posit_chk_delay #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk_i,
    input  logic         reset_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    logic [DEPTH-1:0] vld_q;
    logic [W-1:0]     dat_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            vld_q <= '0;
            for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= valid_i;
            dat_q[0] <= data_i;
            for (int i = 1; i < DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign valid_o = vld_q[DEPTH-1];
    assign data_o  = dat_q[DEPTH-1];

endmodule

// File: rtl/posit_stream_checker.sv
// Scores a fixed-latency posit DUT stream against golden results.
// Define POSIT_CHK_FIRST_ERR_EN to build the first-failure capture registers.
//   state    | meaning
//   ST_IDLE  | after reset, waiting for start
//   ST_RUN   | accepting golden vectors
//   ST_DRAIN | start dropped, waiting for in-flight vectors to retire
//   ST_DONE  | results held until the next start
module posit_stream_checker
    import posit_chk_pkg::*;
#(
    parameter int N       = 8,
    parameter int LATENCY = 8,
    parameter int TOL     = 0,
    parameter int CNT_W   = 32
) (
    input  logic             aclk,
    input  logic             reset,
    input  logic             start,
    input  logic             exp_valid,
    input  logic [N-1:0]     exp_result,
    input  logic             dut_done,
    input  logic [N-1:0]     dut_result,
    output logic [1:0]       state_o,
    output logic             mismatch,
    output logic [N-1:0]     diff,
    output logic [CNT_W-1:0] vec_count,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] missing_count,
    output logic [CNT_W-1:0] extra_count,
    output logic [N-1:0]     max_diff,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [N-1:0]     first_err_exp,
    output logic [N-1:0]     first_err_got
);

    localparam int          IFW   = $clog2(LATENCY + 1);
    localparam logic [N-1:0] TOL_N = N'(TOL);

    chk_state_e       state_q, state_d;
    logic [IFW-1:0]   in_flight_q, in_flight_d;
    logic [CNT_W-1:0] vec_q, vec_d, err_q, err_d, miss_q, miss_d, extra_q, extra_d;
    logic [N-1:0]     diff_q, diff_d, max_q, max_d;
    logic             mismatch_q, mismatch_d;
    logic             load, tail_valid, clear;
    logic [N-1:0]     tail_exp, cur_diff;

    assign load = exp_valid && (state_q == ST_RUN);

    posit_chk_delay #(.W(N), .DEPTH(LATENCY)) u_delay (
        .clk_i   (aclk),
        .reset_i (reset),
        .valid_i (load),
        .data_i  (exp_result),
        .valid_o (tail_valid),
        .data_o  (tail_exp)
    );

    assign cur_diff = N'(abs_diff(64'(tail_exp), 64'(dut_result)));

    always_comb begin
        state_d     = state_q;
        in_flight_d = in_flight_q + IFW'(load) - IFW'(tail_valid);
        vec_d       = vec_q;
        err_d       = err_q;
        miss_d      = miss_q;
        extra_d     = extra_q;
        diff_d      = diff_q;
        max_d       = max_q;
        mismatch_d  = 1'b0;
        clear       = 1'b0;

        case (state_q)
            ST_IDLE:  if (start) begin state_d = ST_RUN; clear = 1'b1; end
            ST_RUN:   if (!start) state_d = ST_DRAIN;
            ST_DRAIN: if (start) state_d = ST_RUN;
                      else if (in_flight_q == '0) state_d = ST_DONE;
            ST_DONE:  if (start) begin state_d = ST_RUN; clear = 1'b1; end
            default:  state_d = ST_IDLE;
        endcase

        if (tail_valid && dut_done) begin
            vec_d  = CNT_W'(sat_inc(64'(vec_q), CNT_W));
            diff_d = cur_diff;
            if (cur_diff > max_q) max_d = cur_diff;
            if (cur_diff > TOL_N) begin
                err_d      = CNT_W'(sat_inc(64'(err_q), CNT_W));
                mismatch_d = 1'b1;
            end
        end else if (tail_valid) begin
            miss_d     = CNT_W'(sat_inc(64'(miss_q), CNT_W));
            mismatch_d = 1'b1;
        end else if (dut_done && (state_q == ST_RUN || state_q == ST_DRAIN)) begin
            extra_d = CNT_W'(sat_inc(64'(extra_q), CNT_W));
        end

        // Clears only happen from IDLE/DONE, where the tail is never valid.
        if (clear) begin
            vec_d   = '0;
            err_d   = '0;
            miss_d  = '0;
            extra_d = '0;
            max_d   = '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_flight_q <= '0;
            vec_q       <= '0;
            err_q       <= '0;
            miss_q      <= '0;
            extra_q     <= '0;
            diff_q      <= '0;
            max_q       <= '0;
            mismatch_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_flight_q <= in_flight_d;
            vec_q       <= vec_d;
            err_q       <= err_d;
            miss_q      <= miss_d;
            extra_q     <= extra_d;
            diff_q      <= diff_d;
            max_q       <= max_d;
            mismatch_q  <= mismatch_d;
        end
    end

    assign state_o       = state_q;
    assign mismatch      = mismatch_q;
    assign diff          = diff_q;
    assign vec_count     = vec_q;
    assign err_count     = err_q;
    assign missing_count = miss_q;
    assign extra_count   = extra_q;
    assign max_diff      = max_q;

`ifdef POSIT_CHK_FIRST_ERR_EN
    logic             fe_seen_q, fe_seen_d;
    logic [CNT_W-1:0] fe_idx_q, fe_idx_d;
    logic [N-1:0]     fe_exp_q, fe_exp_d, fe_got_q, fe_got_d;

    always_comb begin
        fe_seen_d = fe_seen_q;
        fe_idx_d  = fe_idx_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;
        if (clear) begin
            fe_seen_d = 1'b0;
            fe_idx_d  = '0;
            fe_exp_d  = '0;
            fe_got_d  = '0;
        end else if (!fe_seen_q && tail_valid && (!dut_done || cur_diff > TOL_N)) begin
            fe_seen_d = 1'b1;
            fe_idx_d  = vec_q;
            fe_exp_d  = tail_exp;
            fe_got_d  = dut_done ? dut_result : '0;
        end
    end

    always_ff @(posedge aclk) begin
        if (reset) begin
            fe_seen_q <= 1'b0;
            fe_idx_q  <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
        end else begin
            fe_seen_q <= fe_seen_d;
            fe_idx_q  <= fe_idx_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    assign first_err_idx = fe_idx_q;
    assign first_err_exp = fe_exp_q;
    assign first_err_got = fe_got_q;
`else
    assign first_err_idx = '0;
    assign first_err_exp = '0;
    assign first_err_got = '0;
`endif

endmodule
